io_input_cond: RTL and testbench
================================

# io_input_cond

Input-conditioning stage for the memory-mapped I/O input path. It takes raw board switches and push-buttons, synchronises them to `io_clk`, and debounces them. It then assembles the two 32-bit words `in_port0` and `in_port1`, which the I/O input register samples and the CPU reads at 0xC0 and 0xC4. The block also provides sticky key-press flags with CPU write-1-to-clear and a wrapping press counter.

## Interface
**Parameters**
- `DB_LIMIT`, 50000: number of `io_clk` cycles per debounce sample tick. Legal range is 2..65536.

**Ports**
- `io_clk`, input, 1: sole clock. Rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `raw_sw`, input, 10: raw slide switches, active-high, asynchronous to `io_clk`.
- `raw_key`, input, 4: raw push-buttons, active-low (0 = pressed), asynchronous.
- `clr_we`, input, 1: flag-clear strobe from the CPU store path. One cycle.
- `clr_mask`, input, 4: write-1-to-clear mask for the press flags. Sampled when `clr_we` is 1.
- `in_port0`, output, 32: `{22'b0, sw_db[9:0]}`.
- `in_port1`, output, 32: `{16'b0, press_cnt[7:0], key_lvl[3:0], press_flg[3:0]}`.
- `key_irq`, output, 1: present only with `IO_IN_DEBOUNCE_EN`. Equals `|press_flg`.

## Operation
- **Synchroniser:** two flops per bit for all 14 raw inputs.
  - `raw_key` is inverted after synchronisation, so internal key value 1 means pressed.
- **Prescaler:** 16-bit counter.
  - Counts 0..DB_LIMIT-1, then wraps to 0.
  - `tick` is asserted in the cycle the counter equals DB_LIMIT-1.
- **History:** on `tick`, each bit shifts its synchronised value into a per-bit 2-deep history `h[1:0]`.
- **Debounced value:** on `tick`, if `h[1]`, `h[0]` and the current sample are all equal, the debounced bit takes that value. Otherwise it holds.
  - Requirement: three consecutive equal tick samples.
- **Debounced outputs:** `sw_db` holds the switch bits. `key_lvl` holds the key bits, active-high pressed.
- **Press event:** a `key_lvl[i]` 0→1 transition.
  - It sets `press_flg[i]`.
  - Key release (1→0) produces no event.
- **Flag clear:** when `clr_we` is 1, the flags with `clr_mask[i]` = 1 clear.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **Press counter:** `press_cnt` is 8 bits.
  - It increments by 1 in any cycle with at least one press event, even when several keys press in the same cycle.
  - It wraps 255 → 0.
  - There is no clear path other than reset.
- **Outputs:** driven directly from registers. Upper bits are constant 0.

## Timing
- **Reset:** asynchronous, takes effect immediately, including mid-operation.
  - `in_port0` = 0.
  - `in_port1` = 0.
  - `key_irq` = 0.
  - Prescaler = 0.
  - Switch synchroniser and history = 0.
  - Key synchroniser and history = released (internal 0), so no spurious press is seen on reset release.
- **Synchroniser latency:** 2 cycles.
- **Debounce latency:** a stable input change reaches the output 1 cycle after the third tick that samples the new value.
  - Worst case is 2 + 3·DB_LIMIT + 1 cycles.
  - Best case is 2 + 2·DB_LIMIT + 1 cycles.
- **Glitch rejection:** a pulse shorter than DB_LIMIT cycles can be sampled at most once and is never accepted.
- **Flags and counter:** `press_flg` and `press_cnt` update in the same cycle as the `key_lvl` rising edge, so they become visible together with it.
- **Flag-clear latency:** 1 cycle after `clr_we`.
- **Idle strobe:** `clr_we` with `clr_mask` = 0 is a no-op.

## Configuration
- **Macro:** `IO_IN_DEBOUNCE_EN`.
- **Defined:**
  - Prescaler, history and three-sample debounce are built as described.
  - The `key_irq` port exists.
- **Undefined:**
  - No prescaler, no history and no `key_irq` port.
  - `sw_db` and `key_lvl` register the synchronised value every cycle, giving 3-cycle input-to-output latency.
  - Press detection, flags, clear and counter run per cycle with otherwise identical rules.

## Test plan
Benches run with `DB_LIMIT`=4 and `IO_IN_DEBOUNCE_EN` defined unless noted.

- **Reset values:** assert `reset` with `raw_key`=4'hF and `raw_sw`=0 → `in_port0`=0x00000000, `in_port1`=0x00000000, `key_irq`=0. Then deassert reset and hold the inputs for 40 cycles → values unchanged.
- **Switch debounce:** hold `raw_sw`=10'h2A5 → `in_port0`=0x000002A5 within 15 cycles, and still 0 at cycle 10.
- **Glitch rejection:** pulse `raw_sw[0]` high for 3 cycles → `in_port0` stays 0x00000000 for the next 30 cycles.
- **Press and release:** hold `raw_key`=4'b1101 → `in_port1`=0x00000122 and `key_irq`=1. Then release to 4'hF → `in_port1`=0x00000102.
- **Flag clear:**
  - `clr_we`=1 with `clr_mask`=4'b0010 → next cycle `in_port1`=0x00000100 and `key_irq`=0.
  - Force a key1 press event in the same cycle as the clear → flag stays set and `press_cnt` increments.
- **Counter wrap, macro undefined:** apply 256 separated presses of key0 → `in_port1[15:8]` reads 0x00, and each press reaches `key_lvl` 3 cycles after the raw edge.

Source files
------------

// File: rtl/io_input_cond.sv
`timescale 1ns/1ps
// io_input_cond: synchronise and debounce board switches/keys into in_port0/in_port1, with sticky press flags and a press counter.
// Build option IO_IN_DEBOUNCE_EN: tick-based three-sample debounce plus the key_irq port; otherwise a plain per-cycle register.
module io_input_cond #(
  parameter int unsigned DB_LIMIT = 50000
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [9:0]  raw_sw,
  input  logic [3:0]  raw_key,
  input  logic        clr_we,
  input  logic [3:0]  clr_mask,
  output logic [31:0] in_port0,
  output logic [31:0] in_port1
`ifdef IO_IN_DEBOUNCE_EN
  ,
  output logic        key_irq
`endif
);

  if (DB_LIMIT < 2 || DB_LIMIT > 65536) begin : g_bad_limit
    $error("io_input_cond: DB_LIMIT must be in 2..65536");
  end

  // Keys are kept raw (active-low) in the synchroniser, so reset loads "released".
  logic [9:0]  sw_s1_q, sw_s2_q;
  logic [3:0]  key_s1_q, key_s2_q;
  logic [13:0] samp;

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '1;
      key_s2_q <= '1;
    end else begin
      sw_s1_q  <= raw_sw;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= raw_key;
      key_s2_q <= key_s1_q;
    end
  end

  assign samp = {~key_s2_q, sw_s2_q};

  logic [13:0] db_q, db_d;

`ifdef IO_IN_DEBOUNCE_EN
  localparam logic [15:0] PRE_LAST = 16'(DB_LIMIT - 1);

  logic [15:0] pre_q, pre_d;
  logic        tick;
  logic [13:0] h0_q, h0_d, h1_q, h1_d, agree;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? 16'd0 : pre_q + 16'd1;
    agree = ~(h1_q ^ h0_q) & ~(h0_q ^ samp);
    h0_d  = h0_q;
    h1_d  = h1_q;
    db_d  = db_q;
    if (tick) begin
      h1_d = h0_q;
      h0_d = samp;
      db_d = (db_q & ~agree) | (samp & agree);
    end
  end

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      h0_q  <= '0;
      h1_q  <= '0;
    end else begin
      pre_q <= pre_d;
      h0_q  <= h0_d;
      h1_q  <= h1_d;
    end
  end
`else
  assign db_d = samp;
`endif

  // Press detection looks at the next debounced value so flags and counter land with key_lvl.
  logic [3:0] rise, flg_q, flg_d;
  logic [7:0] cnt_q, cnt_d;
  logic       irq_q;

  always_comb begin
    rise  = db_d[13:10] & ~db_q[13:10];
    flg_d = flg_q;
    if (clr_we) begin
      flg_d = flg_d & ~clr_mask;
    end
    flg_d = flg_d | rise;
    cnt_d = cnt_q + {7'd0, |rise};
  end

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      db_q  <= '0;
      flg_q <= '0;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      db_q  <= db_d;
      flg_q <= flg_d;
      cnt_q <= cnt_d;
      irq_q <= |flg_d;
    end
  end

  assign in_port0 = {22'd0, db_q[9:0]};
  assign in_port1 = {16'd0, cnt_q, db_q[13:10], flg_q};

`ifdef IO_IN_DEBOUNCE_EN
  assign key_irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_io_input_cond.sv
`timescale 1ns/1ps
// Scoreboard bench for io_input_cond: stimulus pushes expected port values, a negedge monitor pops and compares.
module tb_io_input_cond;

  localparam int K_EXACT = 0;
  localparam int K_BY    = 1;
  localparam int K_HOLD  = 2;

  logic        io_clk = 1'b0;
  logic        reset;
  logic [9:0]  raw_sw;
  logic [3:0]  raw_key;
  logic        clr_we;
  logic [3:0]  clr_mask;
  logic [31:0] in_port0, in_port1;
`ifdef IO_IN_DEBOUNCE_EN
  logic        key_irq;
`endif

  io_input_cond #(.DB_LIMIT(4)) dut (
    .io_clk   (io_clk),
    .reset    (reset),
    .raw_sw   (raw_sw),
    .raw_key  (raw_key),
    .clr_we   (clr_we),
    .clr_mask (clr_mask),
    .in_port0 (in_port0),
`ifdef IO_IN_DEBOUNCE_EN
    .key_irq  (key_irq),
`endif
    .in_port1 (in_port1)
  );

  always #5 io_clk = ~io_clk;

  int cyc = 0;
  always @(posedge io_clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    int          kind;
    int          due;
    logic [31:0] p0;
    logic [31:0] p1;
    logic        irq;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_to   = 0;

  task automatic judge(input exp_t e, input logic ok);
    n_chk++;
    if (ok) n_pass++;
    else
`ifdef IO_IN_DEBOUNCE_EN
      $display("FAIL %s cyc=%0d in_port0 got %h want %h, in_port1 got %h want %h, key_irq got %b want %b",
               e.nm, cyc, in_port0, e.p0, in_port1, e.p1, key_irq, e.irq);
`else
      $display("FAIL %s cyc=%0d in_port0 got %h want %h, in_port1 got %h want %h",
               e.nm, cyc, in_port0, e.p0, in_port1, e.p1);
`endif
  endtask

  always @(negedge io_clk) begin : monitor
    exp_t c;
    logic hit;
    if (sbq.size() != 0) begin
      c   = sbq[0];
      hit = (in_port0 === c.p0) && (in_port1 === c.p1)
`ifdef IO_IN_DEBOUNCE_EN
            && (key_irq === c.irq)
`endif
            ;
      case (c.kind)
        K_EXACT: if (cyc >= c.due) begin judge(c, hit && (cyc == c.due)); void'(sbq.pop_front()); end
        K_BY:    if (hit || cyc >= c.due) begin judge(c, hit); void'(sbq.pop_front()); end
        default: if (!hit || cyc >= c.due) begin judge(c, hit); void'(sbq.pop_front()); end
      endcase
    end
  end

  function automatic logic [31:0] mk1(input logic [7:0] cnt, input logic [3:0] lvl, input logic [3:0] flg);
    return {16'd0, cnt, lvl, flg};
  endfunction

  task automatic push(input string nm, input int kind, input int due,
                      input logic [31:0] p0, input logic [31:0] p1, input logic irq);
    exp_t e;
    e.nm = nm; e.kind = kind; e.due = due; e.p0 = p0; e.p1 = p1; e.irq = irq;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge io_clk);
    #1;
  endtask

  // Old value must persist until the earliest legal arrival; new value must arrive by the latest.
  task automatic settle(input string nm,
                        input logic [31:0] o0, input logic [31:0] o1, input logic oi,
                        input logic [31:0] n0, input logic [31:0] n1, input logic ni);
`ifdef IO_IN_DEBOUNCE_EN
    push({nm, "_hold"}, K_HOLD, cyc + 10, o0, o1, oi);
    push(nm, K_BY, cyc + 15, n0, n1, ni);
`else
    push({nm, "_old"}, K_EXACT, cyc + 2, o0, o1, oi);
    push(nm, K_EXACT, cyc + 3, n0, n1, ni);
`endif
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge io_clk);
      #1;
      n++;
    end while (sbq.size() != 0 && n < 200);
    if (sbq.size() != 0) begin
      $display("FAIL drain_timeout cyc=%0d pending %0d want 0", cyc, sbq.size());
      n_to++;
      sbq.delete();
    end
  endtask

  initial begin
    reset = 1'b1; raw_sw = '0; raw_key = 4'hF; clr_we = 1'b0; clr_mask = '0;
    step(2);
    push("reset_vals", K_EXACT, cyc, 32'h0, 32'h0, 1'b0);
    step(1);
    reset = 1'b0;
    push("reset_hold40", K_HOLD, cyc + 40, 32'h0, 32'h0, 1'b0);
    drain();

    raw_sw = 10'h2A5;
    settle("sw_db", 32'h0, 32'h0, 1'b0, 32'h2A5, 32'h0, 1'b0);
    drain();
    raw_sw = 10'h000;
    settle("sw_zero", 32'h2A5, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    drain();
`ifdef IO_IN_DEBOUNCE_EN
    raw_sw = 10'h001;
    push("glitch", K_HOLD, cyc + 33, 32'h0, 32'h0, 1'b0);
    step(3);
    raw_sw = 10'h000;
    drain();
`endif

    raw_key = 4'b1101;
    settle("press", 32'h0, 32'h0, 1'b0, 32'h0, 32'h122, 1'b1);
    drain();
    raw_key = 4'hF;
    settle("release", 32'h0, 32'h122, 1'b1, 32'h0, 32'h102, 1'b1);
    drain();

    clr_we = 1'b1; clr_mask = 4'b0000;
    push("idle_clr", K_EXACT, cyc + 1, 32'h0, 32'h102, 1'b1);
    step(1);
    clr_we = 1'b0;
    drain();
    clr_we = 1'b1; clr_mask = 4'b0010;
    push("clr_flag", K_EXACT, cyc + 1, 32'h0, 32'h100, 1'b0);
    step(1);
    clr_we = 1'b0; clr_mask = 4'b0000;
    drain();

    // Clear held across the press edge: the set must win, then the clear takes it next cycle.
    clr_we = 1'b1; clr_mask = 4'b0010; raw_key = 4'b1101;
    settle("set_wins", 32'h0, 32'h100, 1'b0, 32'h0, 32'h222, 1'b1);
`ifdef IO_IN_DEBOUNCE_EN
    push("clr_after", K_BY, cyc + 17, 32'h0, 32'h220, 1'b0);
`else
    push("clr_after", K_EXACT, cyc + 4, 32'h0, 32'h220, 1'b0);
`endif
    drain();
    clr_we = 1'b0; clr_mask = 4'b0000; raw_key = 4'hF;
    settle("release2", 32'h0, 32'h220, 1'b0, 32'h0, 32'h200, 1'b0);
    drain();

    raw_key = 4'b1010;
    settle("multi", 32'h0, 32'h200, 1'b0, 32'h0, 32'h355, 1'b1);
    drain();
    raw_key = 4'hF;
    settle("multi_rel", 32'h0, 32'h355, 1'b1, 32'h0, 32'h305, 1'b1);
    drain();

    raw_sw = 10'h2A5;
    settle("sw_again", 32'h0, 32'h305, 1'b1, 32'h2A5, 32'h305, 1'b1);
    drain();
    #1;
    reset = 1'b1;
    push("async_rst", K_EXACT, cyc, 32'h0, 32'h0, 1'b0);
    step(2);
    reset = 1'b0;
    settle("post_rst", 32'h0, 32'h0, 1'b0, 32'h2A5, 32'h0, 1'b0);
    drain();

`ifndef IO_IN_DEBOUNCE_EN
    for (int i = 0; i < 256; i++) begin
      logic [7:0] pc, nc;
      pc = 8'(i);
      nc = 8'(i + 1);
      raw_key = 4'b1110;
      push("wrap_old", K_EXACT, cyc + 2, 32'h2A5, mk1(pc, 4'b0000, (i == 0) ? 4'b0000 : 4'b0001), 1'b0);
      push("wrap_press", K_EXACT, cyc + 3, 32'h2A5, mk1(nc, 4'b0001, 4'b0001), 1'b1);
      step(4);
      raw_key = 4'hF;
      push("wrap_rel", K_EXACT, cyc + 3, 32'h2A5, mk1(nc, 4'b0000, 4'b0001), 1'b1);
      step(4);
    end
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk + n_to);
    $finish;
  end

endmodule
